// File: rtl/dual_issue_decode.sv
`default_nettype none
// ============================================================================
//  Module      : dual_issue_decode
//  Description : Dual-issue decode stage sitting directly after instruction
//                fetch. Holds one fetched instruction pair, steers each slot
//                to the even or odd pipe, checks register hazards against a
//                per-register latency scoreboard and issues 0, 1 or 2
//                instructions per cycle in program order. Back-pressures
//                fetch through a combinational stall.
//
//  Ports       : clk        clock
//                reset      synchronous, active-high reset
//                instIn     fetched pair, [instWidth-1:0] = slot0 (older),
//                           upper half = slot1; all-ones = empty slot
//                branch     flush request (fetch redirected this cycle)
//                stall      1 = pair on instIn not consumed this cycle
//                evenInst   instruction issued to the even pipe
//                evenValid  evenInst valid
//                oddInst    instruction issued to the odd pipe
//                oddValid   oddInst valid
//
//  Revision    : 1.0 - initial release
// ============================================================================
module dual_issue_decode #(
    parameter int instWidth = 32,
    parameter int regAddrW  = 7,
    parameter int EVEN_LAT  = 6,
    parameter int ODD_LAT   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2*instWidth-1:0] instIn,
    input  logic                   branch,
    output logic                   stall,
    output logic [instWidth-1:0]   evenInst,
    output logic                   evenValid,
    output logic [instWidth-1:0]   oddInst,
    output logic                   oddValid
);

    localparam int                   c_NREG     = 1 << regAddrW;
    localparam logic [instWidth-1:0] c_EMPTY    = '1;
    localparam logic [2:0]           c_EVEN_LAT = 3'(EVEN_LAT);
    localparam logic [2:0]           c_ODD_LAT  = 3'(ODD_LAT);

    // Hold buffer: r_h0 is always the older instruction.
    logic [instWidth-1:0] r_h0;
    logic [instWidth-1:0] r_h1;
    logic                 r_h0_v;
    logic                 r_h1_v;

    // Scoreboard: a register is busy while its counter is nonzero.
    logic [2:0] r_cnt [c_NREG];

    logic [instWidth-1:0] r_even_inst;
    logic [instWidth-1:0] r_odd_inst;
    logic                 r_even_v;
    logic                 r_odd_v;

    // Field decode of both held slots.
    logic                w_pipe0;
    logic                w_pipe1;
    logic [regAddrW-1:0] w_rt0;
    logic [regAddrW-1:0] w_ra0;
    logic [regAddrW-1:0] w_rb0;
    logic [regAddrW-1:0] w_rt1;
    logic [regAddrW-1:0] w_ra1;
    logic [regAddrW-1:0] w_rb1;
    logic [2:0]          w_lat0;
    logic [2:0]          w_lat1;

    assign w_pipe0 = r_h0[instWidth-1];
    assign w_rt0   = r_h0[regAddrW-1:0];
    assign w_ra0   = r_h0[2*regAddrW-1:regAddrW];
    assign w_rb0   = r_h0[3*regAddrW-1:2*regAddrW];
    assign w_pipe1 = r_h1[instWidth-1];
    assign w_rt1   = r_h1[regAddrW-1:0];
    assign w_ra1   = r_h1[2*regAddrW-1:regAddrW];
    assign w_rb1   = r_h1[3*regAddrW-1:2*regAddrW];
    assign w_lat0  = w_pipe0 ? c_ODD_LAT : c_EVEN_LAT;
    assign w_lat1  = w_pipe1 ? c_ODD_LAT : c_EVEN_LAT;

    logic w_free0;
    logic w_free1;
    logic w_h1_indep;
    logic w_iss0;
    logic w_iss1;
    logic w_all_issue;
    logic w_hold_block;

    assign w_free0 = (r_cnt[w_ra0] == 3'd0) && (r_cnt[w_rb0] == 3'd0) &&
                     (r_cnt[w_rt0] == 3'd0);
    assign w_free1 = (r_cnt[w_ra1] == 3'd0) && (r_cnt[w_rb1] == 3'd0) &&
                     (r_cnt[w_rt1] == 3'd0);

    // Pairing rules for slot1 against slot0; irrelevant when slot0 is empty.
    assign w_h1_indep = !r_h0_v ||
                        (w_iss0 && (w_pipe1 != w_pipe0) &&
                         (w_ra1 != w_rt0) && (w_rb1 != w_rt0) &&
                         (w_rt1 != w_rt0));

    assign w_iss0 = !branch && r_h0_v && w_free0;
    assign w_iss1 = !branch && r_h1_v && w_free1 && w_h1_indep;

    assign w_all_issue  = (!r_h0_v || w_iss0) && (!r_h1_v || w_iss1);
    assign w_hold_block = (r_h0_v || r_h1_v) && !w_all_issue;

    assign stall = !reset && !branch && w_hold_block;

    // Hold buffer: flush on branch, refill when fully drained, otherwise
    // shift the leftover younger slot down after a partial issue.
    always_ff @(posedge clk) begin
        if (reset || branch) begin
            r_h0   <= c_EMPTY;
            r_h1   <= c_EMPTY;
            r_h0_v <= 1'b0;
            r_h1_v <= 1'b0;
        end else if (!w_hold_block) begin
            r_h0   <= instIn[instWidth-1:0];
            r_h1   <= instIn[2*instWidth-1:instWidth];
            r_h0_v <= (instIn[instWidth-1:0] != c_EMPTY);
            r_h1_v <= (instIn[2*instWidth-1:instWidth] != c_EMPTY);
        end else if (w_iss0) begin
            r_h0   <= r_h1;
            r_h0_v <= r_h1_v;
            r_h1   <= c_EMPTY;
            r_h1_v <= 1'b0;
        end
    end

    // Scoreboard counters keep retiring across branches; a new issue to a
    // register overrides its decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_NREG; i++) begin
                r_cnt[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < c_NREG; i++) begin
                if (w_iss0 && (w_rt0 == regAddrW'(i))) begin
                    r_cnt[i] <= w_lat0;
                end else if (w_iss1 && (w_rt1 == regAddrW'(i))) begin
                    r_cnt[i] <= w_lat1;
                end else if (r_cnt[i] != 3'd0) begin
                    r_cnt[i] <= r_cnt[i] - 3'd1;
                end
            end
        end
    end

    // Issue registers. When both slots issue they are on different pipes,
    // so the two candidates for a pipe never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_even_inst <= c_EMPTY;
            r_even_v    <= 1'b0;
            r_odd_inst  <= c_EMPTY;
            r_odd_v     <= 1'b0;
        end else begin
            r_even_inst <= c_EMPTY;
            r_even_v    <= 1'b0;
            r_odd_inst  <= c_EMPTY;
            r_odd_v     <= 1'b0;
            if (w_iss0 && !w_pipe0) begin
                r_even_inst <= r_h0;
                r_even_v    <= 1'b1;
            end else if (w_iss1 && !w_pipe1) begin
                r_even_inst <= r_h1;
                r_even_v    <= 1'b1;
            end
            if (w_iss0 && w_pipe0) begin
                r_odd_inst <= r_h0;
                r_odd_v    <= 1'b1;
            end else if (w_iss1 && w_pipe1) begin
                r_odd_inst <= r_h1;
                r_odd_v    <= 1'b1;
            end
        end
    end

    assign evenInst  = r_even_inst;
    assign evenValid = r_even_v;
    assign oddInst   = r_odd_inst;
    assign oddValid  = r_odd_v;

endmodule
`default_nettype wire

// File: tb/tb_dual_issue_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dual_issue_decode
//  Description : Self-checking bench for dual_issue_decode. A cycle-based
//                reference model tracks an ordered queue of held
//                instructions and, per register, the cycle at which its
//                result becomes available. Directed pairs cover the key
//                issue/stall/flush cases, followed by randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_issue_decode;

    localparam int c_EVEN_LAT = 6;
    localparam int c_ODD_LAT  = 4;
    localparam logic [31:0] c_E  = 32'hFFFF_FFFF;
    localparam logic [63:0] c_EE = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch;
    logic [63:0] instIn;
    logic        stall;
    logic [31:0] evenInst;
    logic        evenValid;
    logic [31:0] oddInst;
    logic        oddValid;

    always #5 clk = ~clk;

    dual_issue_decode #(
        .instWidth (32),
        .regAddrW  (7),
        .EVEN_LAT  (c_EVEN_LAT),
        .ODD_LAT   (c_ODD_LAT)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .instIn    (instIn),
        .branch    (branch),
        .stall     (stall),
        .evenInst  (evenInst),
        .evenValid (evenValid),
        .oddInst   (oddInst),
        .oddValid  (oddValid)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mq[$];          // held instructions, oldest first
    longint      ready_at[128];  // first cycle a register may be used again
    longint      cyc = 0;
    logic [31:0] exp_even = c_E;
    logic [31:0] exp_odd  = c_E;
    logic        exp_ev   = 1'b0;
    logic        exp_ov   = 1'b0;
    bit          have_exp = 1'b0;
    bit          m_stall  = 1'b0;
    logic        last_dut_stall = 1'b0;

    function automatic int f_rt(input logic [31:0] x); return int'(x[6:0]);   endfunction
    function automatic int f_ra(input logic [31:0] x); return int'(x[13:7]);  endfunction
    function automatic int f_rb(input logic [31:0] x); return int'(x[20:14]); endfunction
    function automatic int f_lat(input logic [31:0] x); return x[31] ? c_ODD_LAT : c_EVEN_LAT; endfunction

    function automatic bit regs_free(input logic [31:0] x);
        return (cyc >= ready_at[f_ra(x)]) && (cyc >= ready_at[f_rb(x)]) &&
               (cyc >= ready_at[f_rt(x)]);
    endfunction

    function automatic logic [31:0] mk(input bit p, input int rt, input int ra, input int rb);
        logic [31:0] v;
        v = {p, 10'h000, 7'(rb), 7'(ra), 7'(rt)};
        return v;
    endfunction

    // One clock cycle: check last cycle's outputs, drive inputs, evaluate
    // the model and check the combinational stall.
    task automatic step(input logic [63:0] pair, input logic br, input logic rst);
        logic [31:0] h0;
        logic [31:0] h1;
        bit ok0;
        bit ok1;
        bit all_go;
        int n;
        @(negedge clk);
        if (have_exp) begin
            check("evenInst",  evenInst,           exp_even);
            check("evenValid", {31'b0, evenValid}, {31'b0, exp_ev});
            check("oddInst",   oddInst,            exp_odd);
            check("oddValid",  {31'b0, oddValid},  {31'b0, exp_ov});
        end
        reset  = rst;
        branch = br;
        instIn = pair;
        #1;
        exp_even = c_E; exp_ev = 1'b0;
        exp_odd  = c_E; exp_ov = 1'b0;
        if (rst) begin
            m_stall = 1'b0;
            mq.delete();
            foreach (ready_at[i]) ready_at[i] = 0;
        end else begin
            n  = mq.size();
            h0 = (n > 0) ? mq[0] : c_E;
            h1 = (n > 1) ? mq[1] : c_E;
            ok0 = !br && (n >= 1) && regs_free(h0);
            ok1 = !br && (n >= 2) && ok0 && (h1[31] != h0[31]) &&
                  (f_ra(h1) != f_rt(h0)) && (f_rb(h1) != f_rt(h0)) &&
                  (f_rt(h1) != f_rt(h0)) && regs_free(h1);
            all_go  = (n == 0) || (n == 1 && ok0) || (n == 2 && ok1);
            m_stall = !br && (n > 0) && !all_go;
            if (ok0 && !h0[31]) begin exp_even = h0; exp_ev = 1'b1; end
            else if (ok1 && !h1[31]) begin exp_even = h1; exp_ev = 1'b1; end
            if (ok0 && h0[31]) begin exp_odd = h0; exp_ov = 1'b1; end
            else if (ok1 && h1[31]) begin exp_odd = h1; exp_ov = 1'b1; end
            if (ok0) ready_at[f_rt(h0)] = cyc + f_lat(h0) + 1;
            if (ok1) ready_at[f_rt(h1)] = cyc + f_lat(h1) + 1;
            if (br) begin
                mq.delete();
            end else if (!m_stall) begin
                mq.delete();
                if (pair[31:0]  != c_E) mq.push_back(pair[31:0]);
                if (pair[63:32] != c_E) mq.push_back(pair[63:32]);
            end else if (ok0) begin
                void'(mq.pop_front());
            end
        end
        last_dut_stall = stall;
        check("stall", {31'b0, stall}, {31'b0, m_stall});
        have_exp = 1'b1;
        cyc++;
    endtask

    // Present a pair until the model accepts it (bounded); returns how many
    // cycles the DUT reported stall.
    task automatic feed(input logic [63:0] pair, output int dut_stalls);
        dut_stalls = 0;
        for (int k = 0; k < 20; k++) begin
            step(pair, 1'b0, 1'b0);
            if (!m_stall) break;
            if (last_dut_stall) dut_stalls++;
        end
        check("feed_accepted", {31'b0, last_dut_stall}, 32'd0);
    endtask

    task automatic drain(input int cycles);
        int s;
        for (int k = 0; k < cycles; k++) feed(c_EE, s);
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [31:0] v;
        if ($urandom_range(0, 6) == 0) return c_E;
        v = {1'($urandom_range(0, 1)), 10'($urandom), 7'($urandom_range(0, 7)),
             7'($urandom_range(0, 7)), 7'($urandom_range(0, 7))};
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        logic [63:0] p2, p3, p4, pend;
        reset  = 1'b1;
        branch = 1'b0;
        instIn = c_EE;
        p2 = {mk(1'b1, 4, 100, 100), mk(1'b0, 3, 100, 100)};
        p3 = {mk(1'b0, 2, 100, 100), mk(1'b0, 1, 100, 100)};
        p4 = {mk(1'b1, 6, 5, 100),   mk(1'b0, 5, 100, 100)};

        // reset for two cycles
        step(c_EE, 1'b0, 1'b1);
        step(c_EE, 1'b0, 1'b1);
        drain(2);

        // independent even/odd pair: both issue, no stall
        feed(p2, s);
        feed(c_EE, s);
        check("s2_stall_cycles", 32'(s), 32'd0);
        drain(8);

        // two even instructions: serialized, one stall cycle
        feed(p3, s);
        feed(c_EE, s);
        check("s3_stall_cycles", 32'(s), 32'd1);
        drain(8);

        // RAW hazard on the even latency: seven stall cycles
        feed(p4, s);
        feed(c_EE, s);
        check("s4_stall_cycles", 32'(s), 32'd7);
        drain(8);

        // flush while the dependent slot waits
        feed(p4, s);
        step(c_EE, 1'b0, 1'b0);
        step(c_EE, 1'b0, 1'b0);
        step(c_EE, 1'b1, 1'b0);
        feed(p2, s);
        feed(c_EE, s);
        check("s5_stall_cycles", 32'(s), 32'd0);
        drain(8);

        // randomized traffic with occasional flushes and resets
        pend = {rnd_inst(), rnd_inst()};
        for (int i = 0; i < 600; i++) begin
            logic br;
            logic rs;
            br = ($urandom_range(0, 15) == 0);
            rs = ($urandom_range(0, 99) == 0);
            step(pend, br, rs);
            if (!m_stall) pend = {rnd_inst(), rnd_inst()};
        end
        drain(10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
